// File: rtl/knn_history_replay_pkg.sv
// Shared types for the KNN history replay cache: the entry format, default
// sizing and the replay FSM state encoding.
package knn_history_replay_pkg;

    localparam int K_DEF         = 10;
    localparam int NUM_SLOTS_DEF = 4;

    typedef struct packed {
        logic [15:0] distance;
        logic [15:0] index;
    } knn_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_REPLAY
    } replay_state_t;

endpackage

// File: rtl/knn_history_replay_slot_mem.sv
// Storage for NUM_SLOTS top-K result sets plus per-slot counts; one full-set
// write port, one entry read port and one count lookup port.
module knn_slot_mem
    import knn_history_replay_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int CNT_W     = $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [SLOT_W-1:0] i_wr_slot,
    input  logic [CNT_W-1:0]  i_wr_count,
    input  knn_entry_t        i_wr_entry [K],
    input  logic              i_clr_all,
    input  logic [SLOT_W-1:0] i_rd_slot,
    input  logic [CNT_W-1:0]  i_rd_ptr,
    output knn_entry_t        o_rd_entry,
    input  logic [SLOT_W-1:0] i_cnt_slot,
    output logic [CNT_W-1:0]  o_cnt
);

    knn_entry_t       r_mem [NUM_SLOTS][K];
    logic [CNT_W-1:0] r_cnt [NUM_SLOTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                r_cnt[s] <= '0;
                for (int unsigned k = 0; k < K; k++) begin
                    r_mem[s][k] <= '0;
                end
            end
        end else begin
            if (i_wr_en) begin
                for (int unsigned k = 0; k < K; k++) begin
                    r_mem[i_wr_slot][k] <= i_wr_entry[k];
                end
            end
            // Invalidate wins over a same-cycle write; the entries may land but stay unreachable.
            if (i_clr_all) begin
                for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                    r_cnt[s] <= '0;
                end
            end else if (i_wr_en) begin
                r_cnt[i_wr_slot] <= i_wr_count;
            end
        end
    end

    assign o_rd_entry = r_mem[i_rd_slot][i_rd_ptr];
    assign o_cnt      = r_cnt[i_cnt_slot];

endmodule

// File: rtl/knn_history_replay.sv
// Multi-slot top-K history cache: accepts full result sets from the sorter and
// replays one slot's entries, one per handshake, to the distance-compare unit.
module knn_history_replay
    import knn_history_replay_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int CNT_W     = $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              top_k_done,
    input  logic [SLOT_W-1:0] top_k_slot,
    input  logic [CNT_W-1:0]  top_k_count,
    input  knn_entry_t        top_k_entry [K],
    output logic              top_k_ready,
    input  logic              inv_all,
    input  logic              new_query,
    input  logic [SLOT_W-1:0] query_slot,
    output logic              query_ready,
    output knn_entry_t        entry_to_compute,
    output logic              entry_valid,
    input  logic              entry_ready,
    output logic [CNT_W-1:0]  entry_idx,
    output logic              entry_last,
    output logic              replay_done
);

    localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

    replay_state_t     r_state,       w_state_n;
    logic [CNT_W-1:0]  r_ptr,         w_ptr_n;
    logic [SLOT_W-1:0] r_active_slot, w_active_slot_n;
    logic [CNT_W-1:0]  r_active_cnt,  w_active_cnt_n;
    logic              r_done,        w_done_n;

    logic              w_wr_acc;
    logic [CNT_W-1:0]  w_wr_count;
    logic [CNT_W-1:0]  w_slot_cnt;
    logic [CNT_W-1:0]  w_q_count;
    logic              w_is_last;
    knn_entry_t        w_rd_entry;

    assign top_k_ready = !(r_state == ST_REPLAY && top_k_slot == r_active_slot);
    assign query_ready = (r_state == ST_IDLE);
    assign w_wr_acc    = top_k_done && top_k_ready;
    assign w_wr_count  = (top_k_count > K_CNT) ? K_CNT : top_k_count;

    // A same-cycle write to the queried slot supplies the count; its entries are in memory before the first read.
    assign w_q_count = (w_wr_acc && !inv_all && top_k_slot == query_slot) ? w_wr_count : w_slot_cnt;
    assign w_is_last = (r_ptr == r_active_cnt - CNT_W'(1));

    knn_slot_mem #(
        .K         (K),
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .CNT_W     (CNT_W)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_acc),
        .i_wr_slot  (top_k_slot),
        .i_wr_count (w_wr_count),
        .i_wr_entry (top_k_entry),
        .i_clr_all  (inv_all),
        .i_rd_slot  (r_active_slot),
        .i_rd_ptr   (r_ptr),
        .o_rd_entry (w_rd_entry),
        .i_cnt_slot (query_slot),
        .o_cnt      (w_slot_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_active_slot <= '0;
            r_active_cnt  <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_ptr         <= w_ptr_n;
            r_active_slot <= w_active_slot_n;
            r_active_cnt  <= w_active_cnt_n;
            r_done        <= w_done_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_ptr_n         = r_ptr;
        w_active_slot_n = r_active_slot;
        w_active_cnt_n  = r_active_cnt;
        w_done_n        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (new_query) begin
                    if (w_q_count != '0) begin
                        w_active_slot_n = query_slot;
                        w_active_cnt_n  = w_q_count;
                        w_ptr_n         = '0;
                        w_state_n       = ST_REPLAY;
                    end else begin
                        w_done_n = 1'b1;
                    end
                end
            end
            ST_REPLAY: begin
                if (entry_ready) begin
                    if (w_is_last) begin
                        w_ptr_n   = '0;
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_ptr_n = r_ptr + CNT_W'(1);
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign entry_valid      = (r_state == ST_REPLAY);
    assign entry_to_compute = entry_valid ? w_rd_entry : '0;
    assign entry_idx        = entry_valid ? r_ptr : '0;
    assign entry_last       = entry_valid && w_is_last;
    assign replay_done      = r_done;

endmodule

// File: tb/tb_knn_history_replay.sv
// Directed bench for knn_history_replay: table of write/replay vectors plus
// hand-written stall, write-blocking, forwarding, invalidate and reset sequences.
module tb_knn_history_replay;
    import knn_history_replay_pkg::*;

    localparam int K  = 10;
    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       top_k_done = 1'b0;
    logic [1:0] top_k_slot = '0;
    logic [3:0] top_k_count = '0;
    knn_entry_t top_k_entry [K];
    logic       top_k_ready;
    logic       inv_all = 1'b0;
    logic       new_query = 1'b0;
    logic [1:0] query_slot = '0;
    logic       query_ready;
    knn_entry_t entry_to_compute;
    logic       entry_valid;
    logic       entry_ready = 1'b0;
    logic [3:0] entry_idx;
    logic       entry_last;
    logic       replay_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    knn_history_replay #(.K(K), .NUM_SLOTS(NS)) dut (
        .clk              (clk),
        .rst              (rst),
        .top_k_done       (top_k_done),
        .top_k_slot       (top_k_slot),
        .top_k_count      (top_k_count),
        .top_k_entry      (top_k_entry),
        .top_k_ready      (top_k_ready),
        .inv_all          (inv_all),
        .new_query        (new_query),
        .query_slot       (query_slot),
        .query_ready      (query_ready),
        .entry_to_compute (entry_to_compute),
        .entry_valid      (entry_valid),
        .entry_ready      (entry_ready),
        .entry_idx        (entry_idx),
        .entry_last       (entry_last),
        .replay_done      (replay_done)
    );

    function automatic knn_entry_t mk(int slot, int i, int tag);
        knn_entry_t e;
        e.distance = 16'(tag * 256 + slot * 16 + i);
        e.index    = 16'(1000 + tag * 16 + i);
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_wr(int slot, int count, int tag);
        top_k_slot  = 2'(slot);
        top_k_count = 4'(count);
        for (int i = 0; i < K; i++) top_k_entry[i] = mk(slot, i, tag);
    endtask

    task automatic do_write(int slot, int count, int tag);
        @(negedge clk);
        set_wr(slot, count, tag);
        top_k_done = 1'b1;
        #1 chk("wr_ready", 64'(top_k_ready), 64'd1);
        @(negedge clk);
        top_k_done = 1'b0;
    endtask

    // Caller sits at a negedge with entry_ready=1 and the replay already accepted.
    task automatic drain(int slot, int n, int tag, string name);
        for (int i = 0; i < n; i++) begin
            #1;
            chk({name, "_valid"}, 64'(entry_valid), 64'd1);
            chk({name, "_idx"},   64'(entry_idx), 64'(i));
            chk({name, "_entry"}, 64'(entry_to_compute), 64'(mk(slot, i, tag)));
            chk({name, "_last"},  64'(entry_last), 64'(i == n - 1));
            @(negedge clk);
        end
        #1;
        chk({name, "_end_valid"}, 64'(entry_valid), 64'd0);
        chk({name, "_done"},      64'(replay_done), 64'd1);
        @(negedge clk);
        #1 chk({name, "_done_pulse"}, 64'(replay_done), 64'd0);
    endtask

    task automatic start_query(int slot);
        @(negedge clk);
        new_query  = 1'b1;
        query_slot = 2'(slot);
        #1 chk("q_ready", 64'(query_ready), 64'd1);
        @(negedge clk);
        new_query = 1'b0;
    endtask

    task automatic replay_check(int slot, int n, int tag, string name);
        start_query(slot);
        entry_ready = 1'b1;
        drain(slot, n, tag, name);
    endtask

    typedef struct {
        int slot;
        int wr_count;
        int exp_n;
        int tag;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int hs;
        int pat [5];
        int exp_idx [5];

        vecs[0] = '{slot: 2, wr_count: 10, exp_n: 10, tag: 1};
        vecs[1] = '{slot: 0, wr_count: 1,  exp_n: 1,  tag: 2};
        vecs[2] = '{slot: 3, wr_count: 12, exp_n: 10, tag: 3};
        vecs[3] = '{slot: 1, wr_count: 5,  exp_n: 5,  tag: 4};
        vecs[4] = '{slot: 2, wr_count: 0,  exp_n: 0,  tag: 5};
        set_wr(0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(entry_valid), 64'd0);
        chk("rst_entry", 64'(entry_to_compute), 64'd0);
        chk("rst_idx",   64'(entry_idx), 64'd0);
        chk("rst_last",  64'(entry_last), 64'd0);
        chk("rst_done",  64'(replay_done), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_qready",  64'(query_ready), 64'd1);
        chk("rst_wrready", 64'(top_k_ready), 64'd1);

        for (int v = 0; v < 5; v++) begin
            do_write(vecs[v].slot, vecs[v].wr_count, vecs[v].tag);
            replay_check(vecs[v].slot, vecs[v].exp_n, vecs[v].tag, $sformatf("vec%0d", v));
        end

        // Stall: ready pattern 1,0,0,1,1 on a 3-entry set
        do_write(1, 3, 6);
        start_query(1);
        pat     = '{1, 0, 0, 1, 1};
        exp_idx = '{0, 1, 1, 1, 2};
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            entry_ready = pat[c][0];
            #1;
            chk("stall_valid", 64'(entry_valid), 64'd1);
            chk("stall_idx",   64'(entry_idx), 64'(exp_idx[c]));
            chk("stall_entry", 64'(entry_to_compute), 64'(mk(1, exp_idx[c], 6)));
            if (entry_valid && entry_ready) hs++;
            @(negedge clk);
        end
        #1;
        chk("stall_hs",   64'(hs), 64'd3);
        chk("stall_done", 64'(replay_done), 64'd1);
        chk("stall_end",  64'(entry_valid), 64'd0);

        // Write blocked to the active slot, allowed to another slot
        do_write(0, 4, 7);
        start_query(0);
        entry_ready = 1'b0;
        set_wr(0, 2, 9);
        top_k_done = 1'b1;
        #1 chk("blk_same_slot", 64'(top_k_ready), 64'd0);
        @(negedge clk);
        #1 chk("blk_same_slot_hold", 64'(top_k_ready), 64'd0);
        @(negedge clk);
        set_wr(3, 2, 8);
        #1 chk("blk_other_slot", 64'(top_k_ready), 64'd1);
        @(negedge clk);
        top_k_done  = 1'b0;
        entry_ready = 1'b1;
        drain(0, 4, 7, "blk_drain");
        replay_check(3, 2, 8, "blk_slot3");

        // Same-cycle write and query on an idle slot: new data forwarded
        @(negedge clk);
        set_wr(1, 7, 10);
        top_k_done = 1'b1;
        new_query  = 1'b1;
        query_slot = 2'd1;
        #1;
        chk("fwd_qready",  64'(query_ready), 64'd1);
        chk("fwd_wrready", 64'(top_k_ready), 64'd1);
        @(negedge clk);
        top_k_done  = 1'b0;
        new_query   = 1'b0;
        entry_ready = 1'b1;
        drain(1, 7, 10, "fwd");

        // inv_all mid-replay lets the replay finish, then every slot reads empty
        do_write(2, 4, 11);
        start_query(2);
        entry_ready = 1'b0;
        inv_all     = 1'b1;
        @(negedge clk);
        inv_all     = 1'b0;
        entry_ready = 1'b1;
        drain(2, 4, 11, "inv_mid");
        for (int s = 0; s < NS; s++) replay_check(s, 0, 0, $sformatf("inv_empty%0d", s));

        // inv_all beats a same-cycle write
        @(negedge clk);
        set_wr(0, 3, 12);
        top_k_done = 1'b1;
        inv_all    = 1'b1;
        #1 chk("inv_wr_ack", 64'(top_k_ready), 64'd1);
        @(negedge clk);
        top_k_done = 1'b0;
        inv_all    = 1'b0;
        replay_check(0, 0, 0, "inv_wr_drop");

        // Reset at replay index 4
        do_write(3, 8, 13);
        start_query(3);
        entry_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1 chk("rr_idx4", 64'(entry_idx), 64'd4);
        rst = 1'b0;
        #1;
        chk("rr_valid", 64'(entry_valid), 64'd0);
        chk("rr_entry", 64'(entry_to_compute), 64'd0);
        chk("rr_idx",   64'(entry_idx), 64'd0);
        chk("rr_last",  64'(entry_last), 64'd0);
        hs = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (replay_done) hs++;
        end
        rst = 1'b1;
        #1;
        if (replay_done) hs++;
        chk("rr_no_done", 64'(hs), 64'd0);
        chk("rr_qready",  64'(query_ready), 64'd1);
        chk("rr_wrready", 64'(top_k_ready), 64'd1);
        for (int s = 0; s < NS; s++) replay_check(s, 0, 0, $sformatf("rr_empty%0d", s));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/knn_history_replay.md
Name: knn_history_replay

Overview:
Multi-slot successor to the previous-KNN cache. Stores up to NUM_SLOTS independent top-K result sets (one per query stream/context), each with its own valid count. On request it replays one slot's entries, one per handshake, to the parallel distance-compare unit. Sits between the top-K sorter (writer) and the distance-compare front end (reader), under the control logic.

Parameters:
K, 10, maximum entries per slot (>=1)
NUM_SLOTS, 4, number of independent history slots (>=1)
SLOT_W, max(1,$clog2(NUM_SLOTS)), slot index width (derived)
CNT_W, $clog2(K+1), entry count width (derived)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
top_k_done  in  1  write request: store a result set
top_k_slot  in  SLOT_W  destination slot
top_k_count  in  CNT_W  number of valid entries, 0..K
top_k_entry  in  knn_entry_t[K]  result set; indices >= top_k_count ignored
top_k_ready  out  1  write accepted when top_k_done && top_k_ready
inv_all  in  1  clear every slot's count to 0
new_query  in  1  replay request
query_slot  in  SLOT_W  slot to replay
query_ready  out  1  replay request accepted when new_query && query_ready
entry_to_compute  out  knn_entry_t  current replayed entry
entry_valid  out  1  entry_to_compute valid
entry_ready  in  1  consumer accepts entry
entry_idx  out  CNT_W  index of current entry
entry_last  out  1  current entry is final of the set
replay_done  out  1  one-cycle pulse after a replay completes

Behaviour:
- Reset (rst low, async): state IDLE, all counts 0, memory 0, read_ptr 0, active_slot 0; entry_valid 0, entry_last 0, entry_idx 0, entry_to_compute 0, replay_done 0; query_ready 1, top_k_ready 1 once reset deasserts. Reset mid-replay aborts with no replay_done.
- States: IDLE, REPLAY. query_ready = (state==IDLE).
- IDLE, query accepted with count[query_slot]>0: latch active_slot, ptr=0, go REPLAY next cycle. With count==0: stay IDLE, replay_done pulses next cycle, no entries emitted.
- REPLAY: entry_valid=1; entry_to_compute = mem[active_slot][ptr] (combinational from registers); entry_idx=ptr; entry_last=(ptr==count[active_slot]-1). Handshake (valid&&ready) advances ptr; held stable while entry_ready=0. Handshake on last entry: ptr->0, state->IDLE, replay_done pulses the following cycle, query_ready 1 the following cycle (no back-to-back accept on the completing edge).
- Outside REPLAY, entry_to_compute/entry_idx/entry_last driven 0.
- Writes: top_k_ready = !(state==REPLAY && top_k_slot==active_slot); writes to other slots proceed during a replay. Accepted write stores all K entries and count in one cycle; visible to a query accepted next cycle or later. A write and a query to the same slot in the same IDLE cycle: both accepted, replay uses the NEW data (write has priority, forwarded).
- top_k_count > K: clamp to K.
- inv_all: zeroes all counts next edge; takes priority over a same-cycle write (write still acknowledged, then discarded). Does not abort an in-progress replay (active count snapshotted at accept into a REPLAY-local register).
- No multi-outstanding replays; no output buffering beyond the registered pointer.

Decomposition:
- Shared package: knn_entry_t (existing), K default, NUM_SLOTS default, replay state enum.
- Sub-module knn_slot_mem: NUM_SLOTS x K entry array + per-slot count, one full-set write port, one entry read port; top level holds FSM, pointer, handshakes.

Test Plan:
- Reset, write slot 2 count 10 entries e0..e9, query slot 2, entry_ready=1 -> entry_valid from next cycle, e0..e9 on 10 consecutive cycles, entry_last only at idx 9, replay_done pulse 1 cycle after.
- Replay slot 1 count 3 with entry_ready toggling 1,0,0,1,1 -> entries e0,e1,e1,e1,e2 held stable while stalled; exactly 3 handshakes.
- During replay of slot 0, top_k_done to slot 0 -> top_k_ready=0 until IDLE; same-time write to slot 3 -> accepted, later replay of slot 3 returns new data.
- Query empty slot (count 0) -> no entry_valid, replay_done pulse next cycle; write count 12 with K=10 -> replay emits 10 entries.
- Same-cycle write and query on slot 1 in IDLE -> replay returns the newly written set; inv_all mid-replay -> current replay completes, subsequent query on any slot emits none.
- Assert rst low at replay idx 4 -> outputs 0 immediately, no replay_done; after release query_ready=1 and all counts 0.
